stage_wb: RTL and testbench

STAGE_WB -- requirements
Module: stage_wb

---
 rtl/stage_wb_pkg.sv | 15 +
 rtl/stage_wb_regfile.sv | 53 +++++
 rtl/stage_wb.sv | 72 +++++++
 tb/tb_stage_wb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/stage_wb_pkg.sv
// Writeback-stage shared types and constants.
// Holds default widths, the zero-register index and the writeback bundle.
package stage_wb_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] waddr;
    logic [DW_DEF-1:0] wdata;
  } wb_t;

endpackage

// File: rtl/stage_wb_regfile.sv
// Register array with one write port and two bypassed read ports.
// Ports: clk/rst, write port (we/waddr/wdata), reads (re/raddr -> rdata).
module stage_wb_regfile
  import stage_wb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++)
        mem[i] <= '0;
    end else if (we && waddr != ZERO) begin
      mem[waddr] <= wdata;
    end
  end

  // Pending writeback value wins over the array.
  function automatic logic [DW-1:0] rd(
    input logic          re,
    input logic [AW-1:0] ra
  );
    if (!re || ra == ZERO)
      return '0;
    else if (we && waddr == ra)
      return wdata;
    else
      return mem[ra];
  endfunction

  always_comb begin
    rdata1 = rd(re1, raddr1);
    rdata2 = rd(re2, raddr2);
  end

endmodule

// File: rtl/stage_wb.sv
// Writeback stage: result latch with stall/flush plus execute bypass.
// Ports: ex_* in, wb_* latched out, two combinational read ports.
module stage_wb
  import stage_wb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_wdata,
  output logic          wb_we,
  output logic [AW-1:0] wb_waddr,
  output logic [DW-1:0] wb_wdata,
  input  logic          re1,
  input  logic [AW-1:0] raddr1,
  input  logic          re2,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);

  localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

  logic [DW-1:0] rf_rdata1;
  logic [DW-1:0] rf_rdata2;

  // Flush beats stall; rst beats both and clears the same way.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
    end else if (!stall) begin
      wb_we    <= ex_we;
      wb_waddr <= ex_waddr;
      wb_wdata <= ex_wdata;
    end
  end

  stage_wb_regfile #(
    .DW(DW),
    .AW(AW)
  ) u_rf (
    .clk   (clk),
    .rst   (rst),
    .we    (wb_we),
    .waddr (wb_waddr),
    .wdata (wb_wdata),
    .re1   (re1),
    .raddr1(raddr1),
    .re2   (re2),
    .raddr2(raddr2),
    .rdata1(rf_rdata1),
    .rdata2(rf_rdata2)
  );

  // Execute result is newest, so it overrides the latch-level bypass.
  always_comb begin
    rdata1 = rf_rdata1;
    rdata2 = rf_rdata2;
    if (re1 && raddr1 != ZERO && ex_we && ex_waddr == raddr1)
      rdata1 = ex_wdata;
    if (re2 && raddr2 != ZERO && ex_we && ex_waddr == raddr2)
      rdata2 = ex_wdata;
  end

endmodule

// File: tb/tb_stage_wb.sv
// Scoreboard bench for stage_wb.
// Directed scenarios then random traffic against a reference model.
module tb_stage_wb;
  import stage_wb_pkg::*;

  logic        clk = 0;
  logic        rst, stall, flush;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;

  always #5 clk = ~clk;

  stage_wb dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .re1(re1), .raddr1(raddr1), .re2(re2), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2)
  );

  typedef struct {
    wb_t         lat;
    logic [31:0] r1;
    logic [31:0] r2;
  } exp_t;

  exp_t        sb_q[$];
  event        ev_chk;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference state: architectural registers plus the pending result.
  logic [31:0] m_regs [32];
  wb_t         m_lat;

  function automatic logic [31:0] m_read(input logic re,
                                         input logic [4:0] ra);
    if (!re || ra == 0) return 0;
    if (ex_we && ex_waddr == ra) return ex_wdata;
    if (m_lat.we && m_lat.waddr == ra) return m_lat.wdata;
    return m_regs[ra];
  endfunction

  task automatic m_edge();
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_lat = '0;
    end else begin
      if (m_lat.we && m_lat.waddr != 0)
        m_regs[m_lat.waddr] = m_lat.wdata;
      if (flush) m_lat = '0;
      else if (!stall) m_lat = '{ex_we, ex_waddr, ex_wdata};
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic f,
                     input logic we, input logic [4:0] wa,
                     input logic [31:0] wd,
                     input logic e1, input logic [4:0] a1,
                     input logic e2, input logic [4:0] a2);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; flush = f;
    ex_we = we; ex_waddr = wa; ex_wdata = wd;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    #1;
    e.lat = m_lat;
    e.r1  = m_read(e1, a1);
    e.r2  = m_read(e2, a2);
    sb_q.push_back(e);
    ->ev_chk;
    @(posedge clk);
    m_edge();
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    cyc(0, 0, 0, 0, 0, 0, 1, a1, 1, a2);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(ev_chk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        cmp("wb_we",    {31'b0, wb_we},   {31'b0, e.lat.we});
        cmp("wb_waddr", {27'b0, wb_waddr}, {27'b0, e.lat.waddr});
        cmp("wb_wdata", wb_wdata, e.lat.wdata);
        cmp("rdata1",   rdata1,   e.r1);
        cmp("rdata2",   rdata2,   e.r2);
      end
    end
  end

  initial begin
    foreach (m_regs[i]) m_regs[i] = 'x;
    m_lat = 'x;
    rst = 1; stall = 0; flush = 0;
    ex_we = 0; ex_waddr = 0; ex_wdata = 0;
    re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;

    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 1, 3, 1, 0);
    // r3 write then idle; array read after the second edge
    cyc(0, 0, 0, 1, 3, 32'hFF, 1, 3, 1, 4);
    idle(3, 3);
    idle(3, 0);
    // same-cycle forwarding, then ex beats latch
    cyc(0, 0, 0, 1, 5, 32'h1234, 1, 5, 1, 5);
    cyc(0, 0, 0, 1, 5, 32'hABCD, 1, 5, 1, 5);
    idle(5, 5);
    idle(5, 3);
    // r0 write never observable
    cyc(0, 0, 0, 1, 0, 32'hDEAD, 1, 0, 1, 0);
    idle(0, 0);
    idle(0, 0);
    // stall holds r7 while r8 waits; re-commit each cycle
    cyc(0, 0, 0, 1, 7, 32'h55, 1, 7, 1, 8);
    repeat (3) cyc(0, 1, 0, 1, 8, 32'h66, 1, 7, 1, 8);
    cyc(0, 0, 0, 1, 8, 32'h66, 1, 7, 1, 8);
    idle(7, 8);
    idle(7, 8);
    // stall + flush kills r9
    cyc(0, 0, 0, 1, 9, 32'h11, 1, 9, 0, 9);
    idle(9, 9);
    cyc(0, 1, 1, 1, 9, 32'h99, 0, 9, 1, 9);
    idle(9, 9);
    // reset with r2 pending, ex bypass still live during rst
    cyc(0, 0, 0, 1, 2, 32'h77, 1, 2, 1, 2);
    cyc(1, 0, 0, 1, 4, 32'h44, 1, 4, 1, 2);
    idle(2, 4);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) < 2),
          ($urandom_range(0, 99) < 20),
          ($urandom_range(0, 99) < 10),
          1'($urandom),
          5'($urandom_range(0, 7)),
          $urandom,
          ($urandom_range(0, 9) != 0),
          5'($urandom_range(0, 7)),
          ($urandom_range(0, 9) != 0),
          5'($urandom_range(0, 7)));
    end

    @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain left=%0d want=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
